// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the time-of-day clock datapath: the default seconds
// width, time-unit constants, the BCD digit type and the state encoding of the
// BCD-to-seconds converter.
// No ports (package).
// -----------------------------------------------------------------------------
package clock_pkg;

    // 2^17 = 131072 covers a full day (86399 is the largest seconds-of-day).
    localparam int SEC_W        = 17;
    localparam int SEC_PER_DAY  = 86400;
    localparam int SEC_PER_HOUR = 3600;
    localparam int SEC_PER_MIN  = 60;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        ACC,
        DONE
    } state_t;

endpackage

// File: rtl/bcd2sec_seq_if.sv
// -----------------------------------------------------------------------------
// bcd2sec_seq_if
// Handshake bundle between the time-entry logic and the BCD-to-seconds
// converter.
//   in_valid / in_ready   : digit set offered / accepted
//   h1,h2,m1,m2,s1,s2     : BCD digits HH:MM:SS (tens, units)
//   out_valid / out_ready : result offered / taken
//   seconds               : binary seconds-of-day (0 when err)
//   err                   : digit set was not a legal time
// The master modport is the producer of digits and consumer of results;
// the slave modport is the converter itself.
// -----------------------------------------------------------------------------
interface bcd2sec_seq_if
    import clock_pkg::*;
#(
    parameter int SEC_W = clock_pkg::SEC_W
);

    logic             in_valid;
    logic             in_ready;
    bcd_digit_t       h1;
    bcd_digit_t       h2;
    bcd_digit_t       m1;
    bcd_digit_t       m2;
    bcd_digit_t       s1;
    bcd_digit_t       s2;
    logic             out_valid;
    logic             out_ready;
    logic [SEC_W-1:0] seconds;
    logic             err;

    modport master (
        output in_valid, h1, h2, m1, m2, s1, s2, out_ready,
        input  in_ready, out_valid, seconds, err
    );

    modport slave (
        input  in_valid, h1, h2, m1, m2, s1, s2, out_ready,
        output in_ready, out_valid, seconds, err
    );

endinterface

// File: rtl/bcd2sec_seq_check.sv
// -----------------------------------------------------------------------------
// bcd_time_check
// Purely combinational validator for an HH:MM:SS BCD digit set. Shared with
// the alarm-set path.
//   h1,h2,m1,m2,s1,s2 : BCD digits (tens, units of hours, minutes, seconds)
//   valid             : 1 when every digit is decimal, hours < HOURS and the
//                       minute/second tens digits are at most 5
// -----------------------------------------------------------------------------
module bcd_time_check
    import clock_pkg::*;
#(
    parameter int HOURS = 24
) (
    input  bcd_digit_t h1,
    input  bcd_digit_t h2,
    input  bcd_digit_t m1,
    input  bcd_digit_t m2,
    input  bcd_digit_t s1,
    input  bcd_digit_t s2,
    output logic       valid
);

    // Minute and second tens digits run 0..5.
    localparam int TENS_LIMIT = SEC_PER_MIN / 10;

    logic       digits_ok;
    logic [7:0] hours_bin;

    always_comb begin
        digits_ok = (h1 <= 4'd9) && (h2 <= 4'd9) &&
                    (m1 <= 4'd9) && (m2 <= 4'd9) &&
                    (s1 <= 4'd9) && (s2 <= 4'd9);
        // Largest possible value is 15*10+15 = 165, fits in 8 bits.
        hours_bin = ({4'd0, h1} * 8'd10) + {4'd0, h2};
        valid     = digits_ok &&
                    (int'(hours_bin) < HOURS) &&
                    (int'(m1) < TENS_LIMIT) &&
                    (int'(s1) < TENS_LIMIT);
    end

endmodule

// File: rtl/bcd2sec_seq.sv
// -----------------------------------------------------------------------------
// bcd2sec_seq
// Converts six BCD digits HH:MM:SS into a binary seconds-of-day count.
// The digit set is latched on accept, validated in one cycle, then folded into
// an accumulator one digit per cycle (x10 / x6 by shift-add), so a valid set
// produces its result 7 cycles after accept and an invalid one after 2.
//   clk   : system clock
//   rst   : synchronous reset, active-high
//   bus   : slave side of bcd2sec_seq_if (input and output valid/ready,
//           digits, seconds, err)
// -----------------------------------------------------------------------------
module bcd2sec_seq
    import clock_pkg::*;
#(
    parameter int SEC_W = clock_pkg::SEC_W,
    parameter int HOURS = SEC_PER_DAY / SEC_PER_HOUR
) (
    input  logic         clk,
    input  logic         rst,
    bcd2sec_seq_if.slave bus
);

    state_t           state_q, state_d;
    bcd_digit_t       dig_q [6];
    bcd_digit_t       dig_d [6];
    logic [SEC_W-1:0] acc_q, acc_d;
    logic [SEC_W-1:0] seconds_q, seconds_d;
    logic [2:0]       step_q, step_d;
    logic             err_q, err_d;

    logic             time_valid;
    bcd_digit_t       cur_digit;
    logic [SEC_W-1:0] acc_x2;
    logic [SEC_W-1:0] scaled;
    logic [SEC_W-1:0] acc_next;

    // Digit order in dig_q: 0=h1 1=h2 2=m1 3=m2 4=s1 5=s2.
    bcd_time_check #(
        .HOURS (HOURS)
    ) u_check (
        .h1    (dig_q[0]),
        .h2    (dig_q[1]),
        .m1    (dig_q[2]),
        .m2    (dig_q[3]),
        .s1    (dig_q[4]),
        .s2    (dig_q[5]),
        .valid (time_valid)
    );

    // One accumulation step: even steps bring in a units digit (x10), odd
    // steps cross a minute/second boundary whose tens digit is base 6 (x6).
    always_comb begin
        acc_x2 = acc_q << 1;
        if (step_q[0]) begin
            scaled = (acc_q << 2) + acc_x2;
        end else begin
            scaled = (acc_q << 3) + acc_x2;
        end
        case (step_q)
            3'd0:    cur_digit = dig_q[1];
            3'd1:    cur_digit = dig_q[2];
            3'd2:    cur_digit = dig_q[3];
            3'd3:    cur_digit = dig_q[4];
            default: cur_digit = dig_q[5];
        endcase
        acc_next = scaled + SEC_W'(cur_digit);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        dig_d     = dig_q;
        acc_d     = acc_q;
        seconds_d = seconds_q;
        step_d    = step_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    dig_d[0] = bus.h1;
                    dig_d[1] = bus.h2;
                    dig_d[2] = bus.m1;
                    dig_d[3] = bus.m2;
                    dig_d[4] = bus.s1;
                    dig_d[5] = bus.s2;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if (!time_valid) begin
                    err_d     = 1'b1;
                    seconds_d = '0;
                    state_d   = DONE;
                end else begin
                    acc_d   = SEC_W'(dig_q[0]);
                    step_d  = 3'd0;
                    err_d   = 1'b0;
                    state_d = ACC;
                end
            end
            ACC: begin
                acc_d = acc_next;
                if (step_q == 3'd4) begin
                    seconds_d = acc_next;
                    state_d   = DONE;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dig_q     <= '{default: '0};
            acc_q     <= '0;
            seconds_q <= '0;
            step_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dig_q     <= dig_d;
            acc_q     <= acc_d;
            seconds_q <= seconds_d;
            step_q    <= step_d;
            err_q     <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.seconds   = seconds_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd2sec_seq.sv
// -----------------------------------------------------------------------------
// tb_bcd2sec_seq
// Drives a 24-hour and a 12-hour converter with identical digit sets and
// checks results, latency and handshake behaviour against a reference model.
// -----------------------------------------------------------------------------
module tb_bcd2sec_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bcd2sec_seq_if #(.SEC_W(17)) bus24 ();
    bcd2sec_seq_if #(.SEC_W(17)) bus12 ();

    bcd2sec_seq #(.SEC_W(17), .HOURS(24)) dut24 (
        .clk (clk),
        .rst (rst),
        .bus (bus24)
    );

    bcd2sec_seq #(.SEC_W(17), .HOURS(12)) dut12 (
        .clk (clk),
        .rst (rst),
        .bus (bus12)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [23:0] bcd;
        bit          err24;
        int          sec24;
        bit          err12;
        int          sec12;
    } vec_t;

    vec_t vectors [10];

    // Compare one observed value with its expected value.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: a time is legal when every digit is decimal and the
    // hour/minute/second values are in range; result is plain arithmetic.
    function automatic void refModel(input int hours_mod, input logic [23:0] t,
                                     output bit e, output int sec);
        int d [6];
        int h, m, s;
        bit ok;
        d[0] = int'(t[23:20]);
        d[1] = int'(t[19:16]);
        d[2] = int'(t[15:12]);
        d[3] = int'(t[11:8]);
        d[4] = int'(t[7:4]);
        d[5] = int'(t[3:0]);
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (d[i] > 9) ok = 1'b0;
        end
        h  = d[0] * 10 + d[1];
        m  = d[2] * 10 + d[3];
        s  = d[4] * 10 + d[5];
        ok = ok && (h < hours_mod) && (m < 60) && (s < 60);
        e   = !ok;
        sec = ok ? (h * 3600 + m * 60 + s) : 0;
    endfunction

    // Mostly-legal random digit sets with an occasional arbitrary nibble.
    function automatic logic [23:0] randTime();
        logic [3:0] d [6];
        int lim [6];
        lim = '{2, 9, 5, 9, 5, 9};
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 7) == 0) d[i] = 4'($urandom_range(0, 15));
            else                           d[i] = 4'($urandom_range(0, lim[i]));
        end
        return {d[0], d[1], d[2], d[3], d[4], d[5]};
    endfunction

    task automatic driveDigits(input logic [23:0] t, input logic v);
        bus24.h1 = t[23:20]; bus24.h2 = t[19:16];
        bus24.m1 = t[15:12]; bus24.m2 = t[11:8];
        bus24.s1 = t[7:4];   bus24.s2 = t[3:0];
        bus12.h1 = t[23:20]; bus12.h2 = t[19:16];
        bus12.m1 = t[15:12]; bus12.m2 = t[11:8];
        bus12.s1 = t[7:4];   bus12.s2 = t[3:0];
        bus24.in_valid = v;
        bus12.in_valid = v;
    endtask

    // Offer one digit set (called at a negedge), measure latency to out_valid
    // on both converters, hold the result for 'hold' cycles while poking
    // in_valid, then complete the handshake.
    task automatic applyStimulus(input string name, input logic [23:0] t,
                                 input bit e24, input int sec24,
                                 input bit e12, input int sec12, input int hold);
        int n, lat24, lat12;
        checkOutput({name, " in_ready before accept"},
                    32'(bus24.in_ready & bus12.in_ready), 32'd1);
        driveDigits(t, 1'b1);
        @(posedge clk);
        @(negedge clk);
        driveDigits(24'($urandom), 1'b0);
        checkOutput({name, " in_ready busy"},
                    32'(bus24.in_ready | bus12.in_ready), 32'd0);
        lat24 = 0;
        lat12 = 0;
        n = 1;
        while (n <= 20) begin
            if (lat24 == 0 && bus24.out_valid) lat24 = n;
            if (lat12 == 0 && bus12.out_valid) lat12 = n;
            if (lat24 != 0 && lat12 != 0) break;
            @(negedge clk);
            n++;
        end
        checkOutput({name, " latency24"}, 32'(lat24), e24 ? 32'd2 : 32'd7);
        checkOutput({name, " latency12"}, 32'(lat12), e12 ? 32'd2 : 32'd7);
        checkOutput({name, " err24"}, 32'(bus24.err), 32'(e24));
        checkOutput({name, " seconds24"}, 32'(bus24.seconds), 32'(sec24));
        checkOutput({name, " err12"}, 32'(bus12.err), 32'(e12));
        checkOutput({name, " seconds12"}, 32'(bus12.seconds), 32'(sec12));
        for (int i = 0; i < hold; i++) begin
            driveDigits(24'($urandom), (i % 2) == 0);
            @(negedge clk);
            checkOutput({name, " held out_valid"},
                        32'(bus24.out_valid & bus12.out_valid), 32'd1);
            checkOutput({name, " held seconds24"}, 32'(bus24.seconds), 32'(sec24));
            checkOutput({name, " held in_ready"}, 32'(bus24.in_ready), 32'd0);
        end
        driveDigits(24'($urandom), 1'b0);
        bus24.out_ready = 1'b1;
        bus12.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus24.out_ready = 1'b0;
        bus12.out_ready = 1'b0;
        checkOutput({name, " out_valid after take"},
                    32'(bus24.out_valid | bus12.out_valid), 32'd0);
        checkOutput({name, " in_ready after take"},
                    32'(bus24.in_ready & bus12.in_ready), 32'd1);
        checkOutput({name, " seconds24 kept"}, 32'(bus24.seconds), 32'(sec24));
        checkOutput({name, " err12 kept"}, 32'(bus12.err), 32'(e12));
    endtask

    // Abort watchdog.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit seen;
        bit re24, re12;
        int rs24, rs12;
        logic [23:0] rt;

        vectors[0] = '{"t000000", 24'h000000, 1'b0, 0,     1'b0, 0};
        vectors[1] = '{"t235959", 24'h235959, 1'b0, 86399, 1'b1, 0};
        vectors[2] = '{"t123456", 24'h123456, 1'b0, 45296, 1'b1, 0};
        vectors[3] = '{"t240000", 24'h240000, 1'b1, 0,     1'b1, 0};
        vectors[4] = '{"t095A00", 24'h095A00, 1'b1, 0,     1'b1, 0};
        vectors[5] = '{"t076000", 24'h076000, 1'b1, 0,     1'b1, 0};
        vectors[6] = '{"t115959", 24'h115959, 1'b0, 43199, 1'b0, 43199};
        vectors[7] = '{"t120000", 24'h120000, 1'b0, 43200, 1'b1, 0};
        vectors[8] = '{"t0F0000", 24'h0F0000, 1'b1, 0,     1'b1, 0};
        vectors[9] = '{"t195959", 24'h195959, 1'b0, 71999, 1'b1, 0};

        driveDigits(24'h000000, 1'b0);
        bus24.out_ready = 1'b0;
        bus12.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset in_ready", 32'(bus24.in_ready & bus12.in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(bus24.out_valid | bus12.out_valid), 32'd0);
        checkOutput("reset seconds", 32'(bus24.seconds), 32'd0);
        checkOutput("reset err", 32'(bus24.err | bus12.err), 32'd0);

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vectors[i].name, vectors[i].bcd,
                          vectors[i].err24, vectors[i].sec24,
                          vectors[i].err12, vectors[i].sec12, 0);
        end

        // Result held under back-pressure while in_valid is pulsed.
        applyStimulus("backpressure 010001", 24'h010001, 1'b0, 3601, 1'b0, 3601, 10);

        // Reset four cycles into a conversion must abort it.
        driveDigits(24'h101010, 1'b1);
        @(posedge clk);
        @(negedge clk);
        driveDigits(24'($urandom), 1'b0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus24.out_valid || bus12.out_valid) seen = 1'b1;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort in_ready", 32'(bus24.in_ready & bus12.in_ready), 32'd1);
        checkOutput("abort seconds", 32'(bus24.seconds), 32'd0);
        for (int i = 0; i < 8; i++) begin
            if (bus24.out_valid || bus12.out_valid) seen = 1'b1;
            @(negedge clk);
        end
        checkOutput("abort no out_valid", 32'(seen), 32'd0);
        applyStimulus("after abort 000100", 24'h000100, 1'b0, 60, 1'b0, 60, 0);

        // Randomised sets against the reference model.
        for (int k = 0; k < 40; k++) begin
            rt = randTime();
            refModel(24, rt, re24, rs24);
            refModel(12, rt, re12, rs12);
            applyStimulus($sformatf("rand%0d %06h", k, rt), rt,
                          re24, rs24, re12, rs12, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
